// File: rtl/if_id_split_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_split_stage_if
//  Brief    : Fetch-side handshake plus decoded ID-side bundle for the IF/ID stage.
//  Revision : 1.0
// ============================================================================
interface if_id_split_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_ins;
    logic [31:0]       in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        func;
    logic [15:0]       imme;
    logic [25:0]       address;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [31:0]       imm_lui;
    logic [31:0]       pc_plus4;
    logic [31:0]       br_target;
    logic [31:0]       j_target;
    logic [CNT_W-1:0]  ins_count;

    // Master is the fetch/decode environment; slave is the stage itself.
    modport master (
        output in_valid, in_ins, in_pc, flush, out_ready,
        input  in_ready, out_valid, op, rs, rt, rd, shamt, func, imme, address,
               imm_sext, imm_zext, imm_lui, pc_plus4, br_target, j_target, ins_count
    );

    modport slave (
        input  in_valid, in_ins, in_pc, flush, out_ready,
        output in_ready, out_valid, op, rs, rt, rd, shamt, func, imme, address,
               imm_sext, imm_zext, imm_lui, pc_plus4, br_target, j_target, ins_count
    );
endinterface
`default_nettype wire

// File: rtl/if_id_split_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_split_stage
//  Brief    : IF->ID register with 2-entry skid buffer, field split, imm/target precompute.
//  Revision : 1.0
// ============================================================================
module if_id_split_stage #(
    parameter int DATA_W  = 32,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 32
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    if_id_split_stage_if.slave   bus
);

    logic              r_head_valid;
    logic [31:0]       r_head_ins;
    logic [31:0]       r_head_pc;
    logic              r_skid_valid;
    logic [31:0]       r_skid_ins;
    logic [31:0]       r_skid_pc;
    logic [CNT_W-1:0]  r_count;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_deliver;
    logic              w_head_free;
    logic              w_skid_load;
    logic [31:0]       w_ins;
    logic [31:0]       w_seq_pc;
    logic [31:0]       w_br_off;
    logic [31:0]       w_br_raw;
    logic [31:0]       w_j_raw;

    // With the skid slot, readiness depends on registered state only.
    generate
        if (SKID_EN != 0) begin : g_ready_skid
            assign w_in_ready = ~r_skid_valid;
        end else begin : g_ready_single
            assign w_in_ready = ~r_head_valid | bus.out_ready;
        end
    endgenerate

    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_deliver   = r_head_valid & bus.out_ready;
    assign w_head_free = ~r_head_valid | w_deliver;
    assign w_skid_load = w_accept & ~w_head_free & (SKID_EN != 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head_valid <= 1'b0;
            r_head_ins   <= '0;
            r_head_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ins   <= '0;
            r_skid_pc    <= '0;
            r_count      <= '0;
        end else begin
            if (w_deliver) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (bus.flush) begin
                r_head_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_head_free) begin
                // Older skid entry always wins the head slot to keep FIFO order.
                if (r_skid_valid) begin
                    r_head_ins   <= r_skid_ins;
                    r_head_pc    <= r_skid_pc;
                    r_head_valid <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_head_ins   <= bus.in_ins;
                    r_head_pc    <= bus.in_pc;
                    r_head_valid <= 1'b1;
                end else begin
                    r_head_valid <= 1'b0;
                end
            end else if (w_skid_load) begin
                r_skid_ins   <= bus.in_ins;
                r_skid_pc    <= bus.in_pc;
                r_skid_valid <= 1'b1;
            end
        end
    end

    // An empty head presents an all-zero word so ID decodes a NOP.
    assign w_ins    = r_head_valid ? r_head_ins : 32'h0;
    assign w_seq_pc = r_head_pc + 32'd4;
    assign w_br_off = {{14{r_head_ins[15]}}, r_head_ins[15:0], 2'b00};
    assign w_br_raw = w_seq_pc + w_br_off;
    assign w_j_raw  = {w_seq_pc[31:28], r_head_ins[25:0], 2'b00};

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_head_valid;
    assign bus.ins_count = r_count;

    assign bus.op        = w_ins[31:26];
    assign bus.rs        = w_ins[25:21];
    assign bus.rt        = w_ins[20:16];
    assign bus.rd        = w_ins[15:11];
    assign bus.shamt     = w_ins[10:6];
    assign bus.func      = w_ins[5:0];
    assign bus.imme      = w_ins[15:0];
    assign bus.address   = w_ins[25:0];
    assign bus.imm_lui   = {w_ins[15:0], 16'h0000};
    assign bus.pc_plus4  = r_head_valid ? w_seq_pc : 32'h0;
    assign bus.br_target = r_head_valid ? w_br_raw : 32'h0;
    assign bus.j_target  = r_head_valid ? w_j_raw  : 32'h0;

    generate
        if (DATA_W > 16) begin : g_ext_wide
            assign bus.imm_sext = {{(DATA_W-16){w_ins[15]}}, w_ins[15:0]};
            assign bus.imm_zext = {{(DATA_W-16){1'b0}}, w_ins[15:0]};
        end else begin : g_ext_narrow
            assign bus.imm_sext = w_ins[15:0];
            assign bus.imm_zext = w_ins[15:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_if_id_split_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_split_stage
//  Brief    : Directed self-checking bench for if_id_split_stage (skid and single-entry builds).
//  Revision : 1.0
// ============================================================================
module tb_if_id_split_stage;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fails;

    if_id_split_stage_if #(.DATA_W(32), .CNT_W(32)) bus_a ();
    if_id_split_stage_if #(.DATA_W(32), .CNT_W(4))  bus_b ();

    if_id_split_stage #(.DATA_W(32), .SKID_EN(1), .CNT_W(32)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    if_id_split_stage #(.DATA_W(32), .SKID_EN(0), .CNT_W(4)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_a(input logic [31:0] ins, input logic [31:0] pc);
        bus_a.in_valid = 1'b1;
        bus_a.in_ins   = ins;
        bus_a.in_pc    = pc;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset_n  = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_ins = '0; bus_a.in_pc = '0;
        bus_a.flush    = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_ins = '0; bus_b.in_pc = '0;
        bus_b.flush    = 1'b0; bus_b.out_ready = 1'b0;

        // T1: reset values before any clock edge
        #1;
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_in_ready",  bus_a.in_ready,  1);
        check("rst_count",     bus_a.ins_count, 0);
        check("rst_op",        bus_a.op,        0);
        check("rst_br_target", bus_a.br_target, 0);
        step();
        reset_n = 1'b1;

        // T2: lw
        offer_a(32'h8C22FFFC, 32'h00003000);
        bus_a.out_ready = 1'b1;
        step();
        check("lw_out_valid", bus_a.out_valid, 1);
        check("lw_op",        bus_a.op,        6'h23);
        check("lw_rs",        bus_a.rs,        1);
        check("lw_rt",        bus_a.rt,        2);
        check("lw_sext",      bus_a.imm_sext,  32'hFFFFFFFC);
        check("lw_zext",      bus_a.imm_zext,  32'h0000FFFC);
        check("lw_br_target", bus_a.br_target, 32'h00002FF4);

        // T3: jal, accepted in the same cycle lw is delivered
        offer_a(32'h0C000C00, 32'h00003000);
        step();
        check("jal_op",       bus_a.op,        6'h03);
        check("jal_address",  bus_a.address,   26'h0000C00);
        check("jal_j_target", bus_a.j_target,  32'h00003000);
        check("jal_pc_plus4", bus_a.pc_plus4,  32'h00003004);
        check("jal_imm_lui",  bus_a.imm_lui,   32'h0C000000);
        check("jal_count",    bus_a.ins_count, 1);
        bus_a.in_valid = 1'b0;
        step();
        check("idle_out_valid", bus_a.out_valid, 0);
        check("idle_pc_plus4",  bus_a.pc_plus4,  0);
        check("idle_count",     bus_a.ins_count, 2);

        // T4: backpressure with A, B, C back-to-back
        bus_a.out_ready = 1'b0;
        offer_a(32'h11111111, 32'h00000100);
        step();
        check("bp_ready_a", bus_a.in_ready, 1);
        offer_a(32'h22222222, 32'h00000104);
        step();
        check("bp_ready_b", bus_a.in_ready, 0);
        check("bp_head_a",  bus_a.imme,     16'h1111);
        offer_a(32'h33333333, 32'h00000108);
        step();
        check("bp_stall_ready", bus_a.in_ready, 0);
        check("bp_stall_head",  bus_a.imme,     16'h1111);
        bus_a.out_ready = 1'b1;
        step();
        check("bp_head_b",  bus_a.imme,      16'h2222);
        check("bp_ready_c", bus_a.in_ready,  1);
        check("bp_count_a", bus_a.ins_count, 3);
        step();
        check("bp_head_c",  bus_a.imme,      16'h3333);
        check("bp_pc4_c",   bus_a.pc_plus4,  32'h0000010C);
        bus_a.in_valid = 1'b0;
        step();
        check("bp_drained", bus_a.out_valid, 0);
        check("bp_count",   bus_a.ins_count, 5);

        // T5: flush with both entries full and an incoming offer
        bus_a.out_ready = 1'b0;
        offer_a(32'h44440000, 32'h00000200);
        step();
        offer_a(32'h55550000, 32'h00000204);
        step();
        check("fl_full_ready", bus_a.in_ready, 0);
        offer_a(32'h66660000, 32'h00000208);
        bus_a.flush = 1'b1;
        step();
        check("fl_out_valid", bus_a.out_valid, 0);
        check("fl_in_ready",  bus_a.in_ready,  1);
        check("fl_op",        bus_a.op,        0);
        check("fl_imme",      bus_a.imme,      0);
        check("fl_count",     bus_a.ins_count, 5);
        bus_a.flush = 1'b0;

        // Flush coinciding with a delivery still counts it
        offer_a(32'h77770000, 32'h0000020C);
        step();
        bus_a.in_valid  = 1'b0;
        bus_a.flush     = 1'b1;
        bus_a.out_ready = 1'b1;
        step();
        check("fld_count",     bus_a.ins_count, 6);
        check("fld_out_valid", bus_a.out_valid, 0);
        bus_a.flush     = 1'b0;
        bus_a.out_ready = 1'b0;

        // Asynchronous reset in the middle of a cycle
        offer_a(32'h88880000, 32'h00000300);
        step();
        check("ar_pre_valid", bus_a.out_valid, 1);
        bus_a.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_out_valid", bus_a.out_valid, 0);
        check("ar_in_ready",  bus_a.in_ready,  1);
        check("ar_count",     bus_a.ins_count, 0);
        check("ar_imme",      bus_a.imme,      0);
        #1;
        reset_n = 1'b1;

        // T6: single-entry streaming, 4-bit counter wraps
        bus_b.out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            bus_b.in_valid = 1'b1;
            bus_b.in_ins   = 32'(k);
            bus_b.in_pc    = 32'(k * 4);
            step();
            check("st_in_ready", bus_b.in_ready,  1);
            check("st_head",     bus_b.imme,      64'(k));
            check("st_count",    bus_b.ins_count, 64'(k % 16));
        end
        check("st_wrap_count", bus_b.ins_count, 1);
        bus_b.out_ready = 1'b0;
        #1;
        check("st_block_ready", bus_b.in_ready,  0);
        check("st_block_valid", bus_b.out_valid, 1);
        bus_b.in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
